// File: rtl/ps2_key_decoder_pkg.sv
// Shared scan-code constants, decode FSM encoding and track helpers for the
// PS/2 key decoder.
package ps2_key_decoder_pkg;

   localparam int NUM_TRACKS = 6;

   localparam logic [7:0] SC_BREAK = 8'hF0;
   localparam logic [7:0] SC_EXT   = 8'hE0;
   localparam logic [7:0] SC_TRK1  = 8'h1B;
   localparam logic [7:0] SC_TRK2  = 8'h23;
   localparam logic [7:0] SC_TRK3  = 8'h2B;
   localparam logic [7:0] SC_TRK4  = 8'h3B;
   localparam logic [7:0] SC_TRK5  = 8'h42;
   localparam logic [7:0] SC_TRK6  = 8'h4B;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_BREAK     = 2'd1,
      ST_EXT       = 2'd2,
      ST_EXT_BREAK = 2'd3
   } state_t;

   // Track number 1..6 for a mapped code, 0 otherwise.
   function automatic logic [3:0] track_of(input logic [7:0] code);
      case (code)
         SC_TRK1: return 4'd1;
         SC_TRK2: return 4'd2;
         SC_TRK3: return 4'd3;
         SC_TRK4: return 4'd4;
         SC_TRK5: return 4'd5;
         SC_TRK6: return 4'd6;
         default: return 4'd0;
      endcase
   endfunction

   function automatic logic [3:0] lowest_held(input logic [NUM_TRACKS-1:0] held);
      logic [3:0] r;
      r = 4'd0;
      for (int i = NUM_TRACKS - 1; i >= 0; i--)
         if (held[i]) r = 4'(i + 1);
      return r;
   endfunction

endpackage

// File: rtl/ps2_key_decoder_rx.sv
// PS/2 frame receiver: synchronizer, clock glitch filter, falling-edge detect,
// shift register and mid-frame timeout. Parity checked only with PS2_PARITY_CHECK_EN.
module ps2_rx #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 200000
) (
   input  logic       OriginalClk,
   input  logic       Reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] rx_byte,
   output logic       rx_vld,
   output logic       rx_err
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
   localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

   logic          clk_s1, clk_s2, dat_s1, dat_s2;
   logic          filt_clk, filt_d, armed;
   logic [FW-1:0] filt_cnt;
   logic [3:0]    bit_cnt;
   logic [7:0]    sr;
   logic [TW-1:0] to_cnt;
   logic          fall, parity_bad;

   // Synchronizers clear to 0 so a 1 on clk_s2 always comes from the real line;
   // armed then blocks any falling edge until the line has been seen idle-high.
   always_ff @(posedge OriginalClk) begin
      if (Reset) begin
         clk_s1 <= 1'b0;
         clk_s2 <= 1'b0;
         dat_s1 <= 1'b0;
         dat_s2 <= 1'b0;
         armed  <= 1'b0;
      end else begin
         clk_s1 <= ps2_clk;
         clk_s2 <= clk_s1;
         dat_s1 <= ps2_data;
         dat_s2 <= dat_s1;
         if (clk_s2) armed <= 1'b1;
      end
   end

   always_ff @(posedge OriginalClk) begin
      if (Reset) begin
         filt_clk <= 1'b1;
         filt_d   <= 1'b1;
         filt_cnt <= '0;
      end else begin
         filt_d <= filt_clk;
         if (clk_s2 == filt_clk)
            filt_cnt <= '0;
         else if (filt_cnt == FILT_LAST) begin
            filt_clk <= clk_s2;
            filt_cnt <= '0;
         end else
            filt_cnt <= filt_cnt + 1'b1;
      end
   end

   assign fall    = armed & filt_d & ~filt_clk;
   assign rx_byte = sr;

`ifdef PS2_PARITY_CHECK_EN
   logic par;
   always_ff @(posedge OriginalClk) begin
      if (Reset)                       par <= 1'b0;
      else if (fall && bit_cnt == 4'd9) par <= dat_s2;
   end
   assign parity_bad = ~(^{sr, par});
`else
   assign parity_bad = 1'b0;
`endif

   always_ff @(posedge OriginalClk) begin
      if (Reset) begin
         bit_cnt <= 4'd0;
         sr      <= 8'd0;
         to_cnt  <= '0;
         rx_vld  <= 1'b0;
         rx_err  <= 1'b0;
      end else begin
         rx_vld <= 1'b0;
         rx_err <= 1'b0;
         if (fall) begin
            to_cnt <= '0;
            if (bit_cnt == 4'd0) begin
               if (!dat_s2) bit_cnt <= 4'd1;
            end else if (bit_cnt <= 4'd8) begin
               sr      <= {dat_s2, sr[7:1]};
               bit_cnt <= bit_cnt + 4'd1;
            end else if (bit_cnt == 4'd9) begin
               bit_cnt <= 4'd10;
            end else begin
               bit_cnt <= 4'd0;
               if (!dat_s2 || parity_bad) rx_err <= 1'b1;
               else                       rx_vld <= 1'b1;
            end
         end else if (bit_cnt != 4'd0) begin
            // Abandon a stalled frame silently.
            if (to_cnt == TO_LAST) begin
               bit_cnt <= 4'd0;
               to_cnt  <= '0;
            end else
               to_cnt <= to_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 key decoder top: make/break/extended FSM and per-track held tracking.
// Optional parity rejection in ps2_rx via PS2_PARITY_CHECK_EN.
module ps2_key_decoder
   import ps2_key_decoder_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 200000
) (
   input  logic       OriginalClk,
   input  logic       Reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       key_state,
   output logic [3:0] key_ascii,
   output logic [5:0] key_held,
   output logic       frame_error
);

   logic [7:0]            rx_byte;
   logic                  rx_vld, rx_err;
   state_t                state, state_nxt;
   logic [NUM_TRACKS-1:0] held_nxt, trk_mask;
   logic [3:0]            ascii_nxt, trk;

   ps2_rx #(
      .FILTER_LEN     (FILTER_LEN),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_rx (
      .OriginalClk (OriginalClk),
      .Reset       (Reset),
      .ps2_clk     (ps2_clk),
      .ps2_data    (ps2_data),
      .rx_byte     (rx_byte),
      .rx_vld      (rx_vld),
      .rx_err      (rx_err)
   );

   assign trk      = track_of(rx_byte);
   assign trk_mask = (trk == 4'd0) ? '0 : (NUM_TRACKS'(1) << (trk - 4'd1));

   always_comb begin
      state_nxt = state;
      held_nxt  = key_held;
      ascii_nxt = key_ascii;
      if (rx_vld) begin
         state_nxt = ST_IDLE;
         case (state)
            ST_IDLE: begin
               if (rx_byte == SC_BREAK)
                  state_nxt = ST_BREAK;
               else if (rx_byte == SC_EXT)
                  state_nxt = ST_EXT;
               else if (trk != 4'd0 && (key_held & trk_mask) == '0) begin
                  held_nxt  = key_held | trk_mask;
                  ascii_nxt = trk;
               end
            end
            ST_BREAK: begin
               if (trk != 4'd0) begin
                  held_nxt = key_held & ~trk_mask;
                  if (key_ascii == trk) ascii_nxt = lowest_held(held_nxt);
               end
            end
            ST_EXT: begin
               if (rx_byte == SC_BREAK) state_nxt = ST_EXT_BREAK;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge OriginalClk) begin
      if (Reset) begin
         state       <= ST_IDLE;
         key_held    <= '0;
         key_ascii   <= 4'd0;
         key_state   <= 1'b0;
         frame_error <= 1'b0;
      end else begin
         state       <= state_nxt;
         key_held    <= held_nxt;
         key_ascii   <= ascii_nxt;
         key_state   <= |held_nxt;
         frame_error <= rx_err;
      end
   end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed self-checking bench for ps2_key_decoder; honours PS2_PARITY_CHECK_EN.
module tb_ps2_key_decoder;

   localparam int TO = 500;

   logic       OriginalClk = 1'b0;
   logic       Reset       = 1'b1;
   logic       ps2_clk     = 1'b1;
   logic       ps2_data    = 1'b1;
   logic       key_state;
   logic [3:0] key_ascii;
   logic [5:0] key_held;
   logic       frame_error;

   int n_cmp = 0;
   int n_bad = 0;
   int err_pulses = 0;
   int err_base = 0;

   always #5 OriginalClk = ~OriginalClk;

   ps2_key_decoder #(
      .FILTER_LEN     (8),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .OriginalClk (OriginalClk),
      .Reset       (Reset),
      .ps2_clk     (ps2_clk),
      .ps2_data    (ps2_data),
      .key_state   (key_state),
      .key_ascii   (key_ascii),
      .key_held    (key_held),
      .frame_error (frame_error)
   );

   always @(posedge OriginalClk) if (frame_error) err_pulses <= err_pulses + 1;

   task automatic cyc(input int n);
      repeat (n) @(negedge OriginalClk);
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [10:0] frame(input logic [7:0] d, input logic bad_par, input logic stop);
      return {stop, (~^d) ^ bad_par, d, 1'b0};
   endfunction

   task automatic send_bits(input logic [10:0] f, input int n);
      for (int i = 0; i < n; i++) begin
         ps2_data = f[i];
         cyc(8);
         ps2_clk = 1'b0;
         cyc(15);
         ps2_clk = 1'b1;
         cyc(7);
      end
   endtask

   task automatic send(input logic [7:0] d);
      send_bits(frame(d, 1'b0, 1'b1), 11);
      cyc(20);
   endtask

   initial begin
      // reset state
      cyc(4);
      check("rst_state", key_state, 0);
      check("rst_ascii", key_ascii, 0);
      check("rst_held",  key_held,  0);
      check("rst_ferr",  frame_error, 0);
      Reset = 1'b0;
      cyc(5);

      // 0x23 with exact latency: stop edge is the filtered fall, keys 2 cycles later
      send_bits(frame(8'h23, 1'b0, 1'b1), 10);
      ps2_data = 1'b1;
      cyc(8);
      ps2_clk = 1'b0;
      cyc(11);
      check("lat_early_held", key_held, 0);
      cyc(1);
      check("mk23_held",  key_held,  8'h02);
      check("mk23_state", key_state, 1);
      check("mk23_ascii", key_ascii, 2);
      cyc(14);
      ps2_clk = 1'b1;
      cyc(27);
      check("mk23_noerr", 8'(err_pulses), 0);
      send(8'hF0); send(8'h23);
      check("brk23_held",  key_held,  0);
      check("brk23_ascii", key_ascii, 0);
      check("brk23_state", key_state, 0);

      // two keys, repeat make, break of active key
      send(8'h1B); send(8'h4B);
      check("mk4b_ascii", key_ascii, 6);
      check("mk4b_held",  key_held,  8'h21);
      send(8'h1B);
      check("rep1b_ascii", key_ascii, 6);
      send(8'hF0); send(8'h4B);
      check("brk4b_ascii", key_ascii, 1);
      check("brk4b_held",  key_held,  8'h01);
      send(8'hF0); send(8'h1B);
      check("brk1b_held",  key_held,  0);
      check("brk1b_state", key_state, 0);
      check("brk1b_ascii", key_ascii, 0);

      // extended make and break are ignored, FSM returns to idle
      send(8'hE0); send(8'h1B);
      send(8'hE0); send(8'hF0); send(8'h1B);
      check("ext_held",  key_held,  0);
      check("ext_ascii", key_ascii, 0);
      check("ext_state", key_state, 0);
      send(8'h23);
      check("ext_idle_ascii", key_ascii, 2);
      send(8'hF0); send(8'h23);
      check("ext_idle_clr", key_held, 0);

      // parity-inverted 0x2B
      err_base = err_pulses;
      send_bits(frame(8'h2B, 1'b1, 1'b1), 11);
      cyc(20);
`ifdef PS2_PARITY_CHECK_EN
      check("par_err",  8'(err_pulses - err_base), 1);
      check("par_held", key_held, 0);
`else
      check("par_noerr", 8'(err_pulses - err_base), 0);
      check("par_ascii", key_ascii, 3);
      send(8'hF0); send(8'h2B);
      check("par_clr", key_held, 0);
`endif

      // stop bit 0 rejected with a single-cycle error pulse
      err_base = err_pulses;
      send_bits(frame(8'h1B, 1'b0, 1'b0), 11);
      cyc(20);
      check("stop0_err",  8'(err_pulses - err_base), 1);
      check("stop0_held", key_held, 0);

      // a start bit of 1 is ignored
      send_bits(11'h7FF, 1);
      send(8'h2B);
      check("start1_ascii", key_ascii, 3);
      check("start1_held",  key_held,  8'h04);
      send(8'hF0); send(8'h2B);

      // mid-frame timeout
      err_base = err_pulses;
      send_bits(frame(8'h42, 1'b0, 1'b1), 7);
      cyc(TO + 1);
      send(8'h42);
      check("to_noerr", 8'(err_pulses - err_base), 0);
      check("to_ascii", key_ascii, 5);

      // reset mid-frame
      send_bits(frame(8'h3B, 1'b0, 1'b1), 4);
      Reset = 1'b1;
      cyc(3);
      Reset = 1'b0;
      cyc(5);
      check("rstmid_ascii", key_ascii, 0);
      check("rstmid_held",  key_held,  0);
      send(8'h1B);
      check("rst1b_ascii", key_ascii, 1);
      check("rst1b_held",  key_held,  8'h01);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 Parameter FILTER_LEN, default 8: number of consecutive equal synchronized ps2_clk samples required to accept a level change.
REQ-002 Parameter TIMEOUT_CYCLES, default 200000: idle OriginalClk cycles between PS/2 clock falling edges after which a partial frame is discarded.
REQ-003 OriginalClk  input  1  system clock; all logic on its rising edge.
REQ-004 Reset  input  1  reset; synchronous, active-high.
REQ-005 ps2_clk  input  1  PS/2 device clock; asynchronous.
REQ-006 ps2_data  input  1  PS/2 device data; asynchronous.
REQ-007 key_state  output  1  high while any mapped track key is held.
REQ-008 key_ascii  output  4  active track number 1..6; 0 when none is active.
REQ-009 key_held  output  6  per-track held mask; bit n-1 corresponds to track n.
REQ-010 frame_error  output  1  one-cycle pulse when a received frame is rejected.

Function
REQ-011 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer; ps2_clk SHALL then be filtered per FILTER_LEN, and a falling edge of the filtered clock SHALL sample the synchronized ps2_data.
REQ-012 The frame format SHALL be 11 bits: start 0, 8 data bits LSB first, odd parity, stop 1.
REQ-013 A start bit sampled as 1 SHALL be ignored, and the receiver SHALL remain idle.
REQ-014 A stop bit of 0 SHALL discard the frame and pulse frame_error.
REQ-015 The byte-valid strobe SHALL assert exactly one cycle after the edge that samples the stop bit; key outputs SHALL update on the following cycle, so total latency is 2 cycles.
REQ-016 If TIMEOUT_CYCLES elapse with no edge mid-frame, the bit counter SHALL return to idle, with no frame_error and no output change.
REQ-017 The decode FSM SHALL have states IDLE, BREAK, EXT and EXT_BREAK, with these transitions:
- 0xF0 from IDLE goes to BREAK.
- 0xE0 from IDLE goes to EXT.
- 0xF0 from EXT goes to EXT_BREAK.
- Any other byte returns to IDLE after it is processed.
REQ-018 Track mapping SHALL be 0x1B->1, 0x23->2, 0x2B->3, 0x3B->4, 0x42->5, 0x4B->6; all other codes, and every code reached via EXT or EXT_BREAK, SHALL be unmapped and ignored.
REQ-019 A make of track n (byte received in IDLE) SHALL set key_held[n-1] and set key_ascii to n; a repeated make of an already-held key SHALL leave outputs unchanged.
REQ-020 A break of track n (byte received in BREAK) SHALL clear key_held[n-1].
REQ-021 If a break clears the track equal to key_ascii, key_ascii SHALL become the lowest-numbered still-held track, or 0 if none is held.
REQ-022 key_state SHALL equal the registered OR of key_held, updated in the same cycle as key_held.

Reset
REQ-023 While Reset is high, the following SHALL clear on the next rising edge of OriginalClk:
- key_state, key_ascii, key_held and frame_error to 0;
- the FSM to IDLE;
- the bit counter, timeout counter and filter to idle, with the filtered clock at 1.
REQ-024 An assertion of Reset mid-frame SHALL abandon the frame, and a frame SHALL be accepted only from a start bit that begins after Reset deasserts.

Configuration
REQ-025 Macro PS2_PARITY_CHECK_EN:
- When defined, a frame with even parity over data+parity SHALL be discarded and pulse frame_error.
- When undefined, the parity bit SHALL be sampled and ignored.

Structure
REQ-026 A shared package SHALL hold the scan-code constants (SC_BREAK=0xF0, SC_EXT=0xE0, the six track codes), the FSM state encoding, and the track-count constant 6.
REQ-027 Frame reception (synchronizer, filter, edge detect, shift register, timeout, parity) SHALL be a sub-module ps2_rx that outputs an 8-bit byte, a byte-valid strobe and an error strobe; ps2_key_decoder SHALL contain the FSM and key-tracking logic.

Verification
REQ-028 Frame 0x23 -> key_held=000010, key_state=1, key_ascii=2 two cycles after the stop edge.
REQ-029 Frames 0x1B, 0x4B, F0 4B -> after 0x4B: key_ascii=6, key_held=100001; after the break: key_ascii=1, key_held=000001.
REQ-030 Frames E0 1B, then E0 F0 1B -> all outputs unchanged (0) and FSM back in IDLE.
REQ-031 Frame 0x2B with parity bit inverted -> with PS2_PARITY_CHECK_EN: frame_error pulses 1 cycle and key_held=0; without it: key_ascii=3.
REQ-032 Six data bits, then TIMEOUT_CYCLES+1 idle cycles, then full frame 0x42 -> no frame_error, key_ascii=5.
REQ-033 Reset pulsed after 4 bits of frame 0x3B, then full frame 0x1B -> key_ascii=1, key_held=000001.
